// File: rtl/led_nios_sysid_checker.sv
// Avalon-MM read master that checks the system-ID and timestamp words after reset
// and reports the result on status outputs and a blink-coded LED.
module led_nios_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1595379579,
  parameter bit          CHECK_TS     = 1'b1,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned BLINK_SLOW   = 25000000,
  parameter int unsigned BLINK_FAST   = 2500000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        led
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LAT_W     = 2;
  localparam int unsigned BLINK_MAX = (BLINK_SLOW > BLINK_FAST) ? BLINK_SLOW : BLINK_FAST;
  localparam int unsigned CNT_W     = $clog2(BLINK_MAX + 1);
  localparam int unsigned LAT_LAST_I = (READ_LATENCY == 0) ? 0 : READ_LATENCY - 1;

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LAT_LAST_I);
  localparam logic [CNT_W-1:0] SLOW_TOP = CNT_W'(BLINK_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_TOP = CNT_W'(BLINK_FAST - 1);

  typedef enum logic [2:0] {
    RD_ID = 3'd0,
    WT_ID = 3'd1,
    RD_TS = 3'd2,
    WT_TS = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    wait_q, wait_d;
  logic                id_ok_q, id_ok_d;
  logic                ts_ok_q, ts_ok_d;
  logic [DATA_W-1:0]   id_value_q, id_value_d;
  logic [DATA_W-1:0]   ts_value_q, ts_value_d;
  logic                led_q, led_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                capture_id, capture_ts;
  logic [CNT_W-1:0]    blink_top;

  // State and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RD_ID;
      wait_q     <= '0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
      led_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      led_q      <= led_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pass      = id_ok_q & (ts_ok_q | !CHECK_TS);
  assign blink_top = pass ? SLOW_TOP : FAST_TOP;

  // Next-state, capture and blink logic
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    led_d      = led_q;
    cnt_d      = cnt_q;
    capture_id = 1'b0;
    capture_ts = 1'b0;

    case (state_q)
      RD_ID: begin
        wait_d = '0;
        if (READ_LATENCY == 0) begin
          capture_id = 1'b1;
          state_d    = RD_TS;
        end else begin
          state_d = WT_ID;
        end
      end
      WT_ID: begin
        if (wait_q == LAT_LAST) begin
          capture_id = 1'b1;
          wait_d     = '0;
          state_d    = RD_TS;
        end else begin
          wait_d = LAT_W'(wait_q + LAT_W'(1));
        end
      end
      RD_TS: begin
        wait_d = '0;
        if (READ_LATENCY == 0) begin
          capture_ts = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = WT_TS;
        end
      end
      WT_TS: begin
        if (wait_q == LAT_LAST) begin
          capture_ts = 1'b1;
          wait_d     = '0;
          state_d    = DONE;
        end else begin
          wait_d = LAT_W'(wait_q + LAT_W'(1));
        end
      end
      DONE: begin
        if (start) begin
          // Captured words stay visible until the re-run overwrites them
          state_d = RD_ID;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          led_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == blink_top) begin
          cnt_d = '0;
          led_d = ~led_q;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      default: state_d = RD_ID;
    endcase

    if (capture_id) begin
      id_value_d = sysid_readdata;
      id_ok_d    = (sysid_readdata == EXPECTED_ID);
    end
    if (capture_ts) begin
      ts_value_d = sysid_readdata;
      ts_ok_d    = (sysid_readdata == EXPECTED_TS);
    end
  end

  // Read strobe is gated by reset so the first read issues in the cycle reset releases
  assign sysid_read    = reset_n & ((state_q == RD_ID) | (state_q == RD_TS));
  assign sysid_address = (state_q == RD_TS) | (state_q == WT_TS);
  assign busy          = (state_q != DONE);
  assign done          = (state_q == DONE);
  assign id_ok         = id_ok_q;
  assign ts_ok         = ts_ok_q;
  assign id_value      = id_value_q;
  assign ts_value      = ts_value_q;
  assign led           = led_q;

endmodule
